// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU front end.
// Covers widths, sequencer states and the named one-hot opcodes.
package alu_pkg;
    localparam int NUM_OPS  = 8;
    localparam int OPCODE_W = 16;
    localparam int OPSEL_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_SHR2_FILL = 16'h0001;
    localparam logic [OPCODE_W-1:0] OP_SHL2_FILL = 16'h0002;
    localparam logic [OPCODE_W-1:0] OP_ADD       = 16'h0004;
    localparam logic [OPCODE_W-1:0] OP_SUB       = 16'h0008;
    localparam logic [OPCODE_W-1:0] OP_AND       = 16'h0010;
    localparam logic [OPCODE_W-1:0] OP_OR        = 16'h0020;
    localparam logic [OPCODE_W-1:0] OP_XOR       = 16'h0040;
    localparam logic [OPCODE_W-1:0] OP_ROL3      = 16'h0080;

    function automatic logic [OPCODE_W-1:0] onehot(input logic [OPSEL_W-1:0] idx);
        logic [OPCODE_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/alu_issue_sequencer_if.sv
// Operand/opcode bus between the controller and the ALU issue sequencer.
// The master side drives the commands, and the slave side is the sequencer.
interface alu_issue_sequencer_if;
    import alu_pkg::*;

    logic [7:0]          data_in;
    logic                load_a;
    logic                load_b;
    logic [OPSEL_W-1:0]  op_sel;
    logic                sweep;
    logic                go;
    logic [7:0]          a_out;
    logic [7:0]          b_out;
    logic [OPCODE_W-1:0] opcode;
    logic                busy;
    logic                done;
    logic                illegal;

    modport master (
        output data_in, load_a, load_b, op_sel, sweep, go,
        input  a_out, b_out, opcode, busy, done, illegal
    );

    modport slave (
        input  data_in, load_a, load_b, op_sel, sweep, go,
        output a_out, b_out, opcode, busy, done, illegal
    );
endinterface

// File: rtl/alu_opcode_decoder.sv
// Turns a binary op index into the ALU's one-hot opcode word.
// The decoder is purely combinational, and the caller registers the result.
module alu_opcode_decoder
    import alu_pkg::*;
(
    input  logic [OPSEL_W-1:0]  idx,
    output logic [OPCODE_W-1:0] code
);
    always_comb begin
        code = onehot(idx);
    end
endmodule

// File: rtl/alu_issue_sequencer.sv
// Captures the ALU operands and issues one-hot opcodes, one op or a full sweep.
// Each opcode is held for HOLD_CYCLES so that the ALU settles before done.
module alu_issue_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_OPS     = alu_pkg::NUM_OPS
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_issue_sequencer_if.slave  bus
);
    import alu_pkg::*;

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t              state;
    logic                run_mode;
    logic [OPSEL_W-1:0]  op_idx;
    logic [CNT_W-1:0]    hold_cnt;
    logic [7:0]          a_reg, b_reg;
    logic [OPCODE_W-1:0] opcode_reg;
    logic                busy_reg, done_reg, illegal_reg;

    logic [OPSEL_W-1:0]  dec_idx;
    logic [OPCODE_W-1:0] dec_code;
    logic                last_hold, more_ops, sel_legal;

    assign last_hold = (hold_cnt == CNT_W'(HOLD_CYCLES - 1));
    assign more_ops  = run_mode && (int'(op_idx) < NUM_OPS - 1);
    assign sel_legal = int'(bus.op_sel) < NUM_OPS;

    // The decoder input serves both paths: the first op at go, and the next op within a sweep.
    always_comb begin
        dec_idx = op_idx + OPSEL_W'(1);
        if (state == IDLE)
            dec_idx = bus.sweep ? '0 : bus.op_sel;
    end

    alu_opcode_decoder u_dec (
        .idx  (dec_idx),
        .code (dec_code)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            run_mode    <= 1'b0;
            op_idx      <= '0;
            hold_cnt    <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            opcode_reg  <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load_a) a_reg <= bus.data_in;
                    if (bus.load_b) b_reg <= bus.data_in;
                    if (bus.go) begin
                        if (bus.sweep || sel_legal) begin
                            run_mode   <= bus.sweep;
                            op_idx     <= dec_idx;
                            opcode_reg <= dec_code;
                            hold_cnt   <= '0;
                            busy_reg   <= 1'b1;
                            state      <= HOLD;
                            if (!bus.sweep) illegal_reg <= 1'b0;
                        end else begin
                            illegal_reg <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (last_hold) begin
                        hold_cnt <= '0;
                        if (more_ops) begin
                            op_idx     <= dec_idx;
                            opcode_reg <= dec_code;
                        end else begin
                            // opcode stays put so the ALU result remains stable while idle
                            done_reg <= 1'b1;
                            busy_reg <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_out   = a_reg;
    assign bus.b_out   = b_reg;
    assign bus.opcode  = opcode_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.illegal = illegal_reg;
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer, using a default build and a HOLD_CYCLES=1 build.
// Table-driven single-op vectors are followed by hand-written sweep, reset and fast-hold sequences.
module tb_alu_issue_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    alu_issue_sequencer_if bus ();
    alu_issue_sequencer_if bus1 ();

    alu_issue_sequencer #(.HOLD_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    alu_issue_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        la, lb;
        logic [3:0]  sel;
        logic        sw, go;
        logic [7:0]  ea, eb;
        logic [15:0] eop;
        logic        ebusy, edone, eill;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic la, input logic lb,
                         input logic [3:0] sel, input logic sw, input logic go);
        bus.data_in = d;
        bus.load_a  = la;
        bus.load_b  = lb;
        bus.op_sel  = sel;
        bus.sweep   = sw;
        bus.go      = go;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [15:0] eop, input logic ebusy, input logic edone,
                           input logic eill);
        chk({tag, ".a_out"},   bus.a_out,   ea);
        chk({tag, ".b_out"},   bus.b_out,   eb);
        chk({tag, ".opcode"},  bus.opcode,  eop);
        chk({tag, ".busy"},    bus.busy,    ebusy);
        chk({tag, ".done"},    bus.done,    edone);
        chk({tag, ".illegal"}, bus.illegal, eill);
    endtask

    initial begin
        // data la lb sel sw go | a b opcode busy done illegal
        tbl[0]  = '{8'h5A, 1, 0, 4'd0, 0, 0, 8'h5A, 8'h00, 16'h0000, 0, 0, 0};
        tbl[1]  = '{8'h3C, 0, 1, 4'd0, 0, 0, 8'h5A, 8'h3C, 16'h0000, 0, 0, 0};
        tbl[2]  = '{8'h00, 0, 0, 4'd5, 0, 1, 8'h5A, 8'h3C, 16'h0020, 1, 0, 0};
        tbl[3]  = '{8'h11, 1, 0, 4'd0, 0, 0, 8'h5A, 8'h3C, 16'h0020, 1, 0, 0};
        tbl[4]  = '{8'h00, 0, 0, 4'd0, 0, 0, 8'h5A, 8'h3C, 16'h0020, 1, 0, 0};
        tbl[5]  = '{8'h00, 0, 0, 4'd3, 0, 1, 8'h5A, 8'h3C, 16'h0020, 1, 0, 0};
        tbl[6]  = '{8'h00, 0, 0, 4'd0, 0, 0, 8'h5A, 8'h3C, 16'h0020, 0, 1, 0};
        tbl[7]  = '{8'h00, 0, 0, 4'd0, 0, 0, 8'h5A, 8'h3C, 16'h0020, 0, 0, 0};
        tbl[8]  = '{8'h00, 0, 0, 4'd9, 0, 1, 8'h5A, 8'h3C, 16'h0020, 0, 0, 1};
        tbl[9]  = '{8'h00, 0, 0, 4'd0, 0, 0, 8'h5A, 8'h3C, 16'h0020, 0, 0, 1};
        tbl[10] = '{8'h11, 1, 0, 4'd2, 0, 1, 8'h11, 8'h3C, 16'h0004, 1, 0, 0};
        tbl[11] = '{8'h00, 0, 0, 4'd0, 0, 0, 8'h11, 8'h3C, 16'h0004, 1, 0, 0};
        tbl[12] = '{8'h00, 0, 0, 4'd0, 0, 0, 8'h11, 8'h3C, 16'h0004, 1, 0, 0};
        tbl[13] = '{8'h00, 0, 0, 4'd0, 0, 0, 8'h11, 8'h3C, 16'h0004, 1, 0, 0};
        tbl[14] = '{8'h00, 0, 0, 4'd0, 0, 0, 8'h11, 8'h3C, 16'h0004, 0, 1, 0};
        tbl[15] = '{8'h77, 1, 1, 4'd0, 0, 0, 8'h77, 8'h77, 16'h0004, 0, 0, 0};

        reset = 1'b1;
        drive(8'h00, 0, 0, 4'd0, 0, 0);
        bus1.data_in = '0; bus1.load_a = 0; bus1.load_b = 0;
        bus1.op_sel  = '0; bus1.sweep  = 0; bus1.go     = 0;
        #12;
        chk_all("reset", 8'h00, 8'h00, 16'h0000, 0, 0, 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].data, tbl[i].la, tbl[i].lb, tbl[i].sel, tbl[i].sw, tbl[i].go);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].eop,
                    tbl[i].ebusy, tbl[i].edone, tbl[i].eill);
        end

        // The full sweep holds each op for 4 cycles and produces a single done.
        // Changes to sweep, op_sel and go during the run must be ignored.
        drive(8'h00, 0, 0, 4'd0, 1, 1);
        tick();
        bus.go = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == 5) drive(8'h00, 0, 0, 4'd9, 0, 1);
            if (k == 10) drive(8'h00, 0, 0, 4'd0, 0, 0);
            chk($sformatf("sweep%0d.opcode", k), bus.opcode, 32'h1 << (k / 4));
            chk($sformatf("sweep%0d.busy", k), bus.busy, 1);
            chk($sformatf("sweep%0d.done", k), bus.done, 0);
            tick();
        end
        chk("sweep_end.done", bus.done, 1);
        chk("sweep_end.busy", bus.busy, 0);
        chk("sweep_end.opcode", bus.opcode, 16'h0080);
        chk("sweep_end.illegal", bus.illegal, 0);
        tick();
        chk("sweep_after.done", bus.done, 0);

        // Reset at op 3 with hold count 2 must clear all outputs at once and produce no done.
        drive(8'h00, 0, 0, 4'd0, 1, 1);
        tick();
        bus.go = 1'b0;
        repeat (14) tick();
        chk("pre_reset.opcode", bus.opcode, 16'h0008);
        #2 reset = 1'b1;
        #1;
        chk_all("mid_reset", 8'h00, 8'h00, 16'h0000, 0, 0, 0);
        tick();
        #2 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post_reset%0d.done", k), bus.done, 0);
            chk($sformatf("post_reset%0d.opcode", k), bus.opcode, 0);
        end

        // In the HOLD_CYCLES=1 build, the opcode changes every cycle and done follows 8 cycles after go.
        bus1.sweep = 1'b1;
        bus1.go    = 1'b1;
        tick();
        bus1.go = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fast%0d.opcode", k), bus1.opcode, 32'h1 << k);
            chk($sformatf("fast%0d.done", k), bus1.done, 0);
            tick();
        end
        chk("fast_end.done", bus1.done, 1);
        chk("fast_end.busy", bus1.busy, 0);
        chk("fast_end.opcode", bus1.opcode, 16'h0080);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
